// File: rtl/nb_clk_pkg.sv
// Shared types and constants for the on-chip oscillator frequency meter.
package nb_clk_pkg;

  typedef enum logic [1:0] {
    WARMUP  = 2'd0,
    IDLE    = 2'd1,
    MEASURE = 2'd2
  } state_e;

  localparam int unsigned SYS_CLK_HZ      = 27_000_000;
  localparam int unsigned OSC_NOM_HZ      = 11_363_636;
  localparam int unsigned DEF_GATE_CYCLES = 27_000;
  localparam int unsigned DEF_CNT_W       = 16;
  localparam int unsigned DEF_LO_LIMIT    = 10_800;
  localparam int unsigned DEF_HI_LIMIT    = 11_900;

  // Bits needed to hold 0..v-1; never less than 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/osc_edge_sync.sv
// Two-flop synchronizer for the free-running oscillator plus a rising-edge
// detector on the synchronized signal.
module osc_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic oscin,
  output logic edge_o
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= oscin;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign edge_o = s2_q & ~s3_q;

endmodule

// File: rtl/osc_freq_meter.sv
// Counts oscillator rising edges inside a fixed window of clk cycles and
// reports the count with range and saturation flags.
module osc_freq_meter
  import nb_clk_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned LO_LIMIT    = DEF_LO_LIMIT,
  parameter int unsigned HI_LIMIT    = DEF_HI_LIMIT,
  parameter bit          CONTINUOUS  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             oscin,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             in_range,
  output logic             overflow
);

  localparam int unsigned        GATE_W    = clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0]  GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   LO_C      = CNT_W'(LO_LIMIT);
  localparam logic [CNT_W-1:0]   HI_C      = CNT_W'(HI_LIMIT);

  state_e            state_q;
  logic [1:0]        warm_q;
  logic [GATE_W-1:0] gate_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ovf_acc_q;
  logic              busy_q, done_q, in_range_q, overflow_q;
  logic [CNT_W-1:0]  count_q;

  logic              osc_edge;
  logic [CNT_W-1:0]  cnt_d;
  logic              ovf_d;
  logic              in_range_d;

  osc_edge_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .oscin  (oscin),
    .edge_o (osc_edge)
  );

  // Saturating edge count including the current cycle, and its verdict.
  always_comb begin
    cnt_d      = cnt_q;
    ovf_d      = ovf_acc_q;
    in_range_d = 1'b0;
    if (osc_edge) begin
      if (&cnt_q) ovf_d = 1'b1;
      else        cnt_d = cnt_q + CNT_W'(1);
    end
    in_range_d = (cnt_d >= LO_C) && (cnt_d <= HI_C) && !ovf_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= WARMUP;
      warm_q     <= 2'd0;
      gate_q     <= '0;
      cnt_q      <= '0;
      ovf_acc_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      count_q    <= '0;
      in_range_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        // Lets the synchronizer settle so a high oscin is not seen as an edge.
        WARMUP: begin
          warm_q <= warm_q + 2'd1;
          if (warm_q == 2'd2) state_q <= IDLE;
        end
        IDLE: begin
          gate_q    <= '0;
          cnt_q     <= '0;
          ovf_acc_q <= 1'b0;
          if (start || CONTINUOUS) begin
            state_q <= MEASURE;
            busy_q  <= 1'b1;
          end
        end
        MEASURE: begin
          if (gate_q == GATE_LAST) begin
            count_q    <= cnt_d;
            overflow_q <= ovf_d;
            in_range_q <= in_range_d;
            done_q     <= 1'b1;
            gate_q     <= '0;
            cnt_q      <= '0;
            ovf_acc_q  <= 1'b0;
            if (!CONTINUOUS) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            gate_q    <= gate_q + GATE_W'(1);
            cnt_q     <= cnt_d;
            ovf_acc_q <= ovf_d;
          end
        end
        default: state_q <= WARMUP;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign count    = count_q;
  assign in_range = in_range_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_osc_freq_meter.sv
// Directed bench: one-shot, saturating and continuous meter instances.
module tb_osc_freq_meter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_m = 1'b1, rst_o = 1'b1;
  logic osc_m = 1'b0, osc_s = 1'b0, osc_c = 1'b0;
  logic start_m = 1'b0, start_s = 1'b0, start_c = 1'b0;

  logic       busy_m, done_m, inr_m, ovf_m;
  logic [7:0] count_m;
  logic       busy_s, done_s, inr_s, ovf_s;
  logic [3:0] count_s;
  logic       busy_c, done_c, inr_c, ovf_c;
  logic [7:0] count_c;

  int n_checks = 0;
  int n_fail   = 0;

  // Oscillator models: mode 0 = stuck low, 1 = stuck high, 2 = square wave.
  int mode_m = 2, per_m = 5, ph_m = 0;
  int per_s = 4, ph_s = 0;
  int per_c = 5, ph_c = 0;

  always @(negedge clk) begin
    ph_m  = (ph_m + 1) % per_m;
    osc_m = (mode_m == 2) ? (ph_m < per_m / 2) : (mode_m == 1);
    ph_s  = (ph_s + 1) % per_s;
    osc_s = (ph_s < per_s / 2);
    ph_c  = (ph_c + 1) % per_c;
    osc_c = (ph_c < per_c / 2);
  end

  osc_freq_meter #(.GATE_CYCLES(100), .CNT_W(8), .LO_LIMIT(18), .HI_LIMIT(22),
                   .CONTINUOUS(1'b0)) u_main (
    .clk(clk), .rst(rst_m), .oscin(osc_m), .start(start_m),
    .busy(busy_m), .done(done_m), .count(count_m), .in_range(inr_m), .overflow(ovf_m));

  osc_freq_meter #(.GATE_CYCLES(100), .CNT_W(4), .LO_LIMIT(10), .HI_LIMIT(14),
                   .CONTINUOUS(1'b0)) u_sat (
    .clk(clk), .rst(rst_o), .oscin(osc_s), .start(start_s),
    .busy(busy_s), .done(done_s), .count(count_s), .in_range(inr_s), .overflow(ovf_s));

  osc_freq_meter #(.GATE_CYCLES(100), .CNT_W(8), .LO_LIMIT(18), .HI_LIMIT(22),
                   .CONTINUOUS(1'b1)) u_cont (
    .clk(clk), .rst(rst_o), .oscin(osc_c), .start(start_c),
    .busy(busy_c), .done(done_c), .count(count_c), .in_range(inr_c), .overflow(ovf_c));

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulse start on the main meter and observe it for max_cyc cycles;
  // start is re-pulsed at window cycles re1/re2 (0 = none).
  task automatic run_window(input int max_cyc, input int re1, input int re2,
                            output int busy_cyc, output int done_at, output int ndone);
    busy_cyc = 0; done_at = -1; ndone = 0;
    start_m = 1'b1;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      start_m = (i == re1 || i == re2) ? 1'b1 : 1'b0;
      if (busy_m) busy_cyc++;
      if (done_m) begin
        ndone++;
        if (done_at < 0) done_at = i;
      end
    end
    start_m = 1'b0;
  endtask

  task automatic test_reset;
    tick(2);
    n_checks++; if ({busy_m, done_m, inr_m, ovf_m} !== 4'b0) begin n_fail++;
      $display("FAIL rst_main_flags: got %b expected 0000", {busy_m, done_m, inr_m, ovf_m}); end
    n_checks++; if (count_m !== 8'd0) begin n_fail++;
      $display("FAIL rst_main_count: got %0d expected 0", count_m); end
    n_checks++; if ({busy_s, done_s, inr_s, ovf_s, count_s} !== 8'b0) begin n_fail++;
      $display("FAIL rst_sat_outputs: got %b expected 0", {busy_s, done_s, inr_s, ovf_s, count_s}); end
    n_checks++; if ({busy_c, done_c, inr_c, ovf_c, count_c} !== 12'b0) begin n_fail++;
      $display("FAIL rst_cont_outputs: got %b expected 0", {busy_c, done_c, inr_c, ovf_c, count_c}); end
    rst_m = 1'b0; rst_o = 1'b0;
    tick(6);
  endtask

  task automatic test_square5;
    int bc, da, nd;
    mode_m = 2;
    run_window(130, 0, 0, bc, da, nd);
    n_checks++; if (bc != 100) begin n_fail++; $display("FAIL sq5_busy_cycles: got %0d expected 100", bc); end
    n_checks++; if (da != 101) begin n_fail++; $display("FAIL sq5_done_at: got %0d expected 101", da); end
    n_checks++; if (nd != 1) begin n_fail++; $display("FAIL sq5_done_pulses: got %0d expected 1", nd); end
    n_checks++; if (count_m !== 8'd20) begin n_fail++; $display("FAIL sq5_count: got %0d expected 20", count_m); end
    n_checks++; if (inr_m !== 1'b1) begin n_fail++; $display("FAIL sq5_in_range: got %b expected 1", inr_m); end
    n_checks++; if (ovf_m !== 1'b0) begin n_fail++; $display("FAIL sq5_overflow: got %b expected 0", ovf_m); end
  endtask

  task automatic test_stuck;
    int bc, da, nd;
    mode_m = 0;
    tick(10);
    run_window(130, 0, 0, bc, da, nd);
    n_checks++; if (nd != 1) begin n_fail++; $display("FAIL low_done_pulses: got %0d expected 1", nd); end
    n_checks++; if (count_m !== 8'd0) begin n_fail++; $display("FAIL low_count: got %0d expected 0", count_m); end
    n_checks++; if (inr_m !== 1'b0) begin n_fail++; $display("FAIL low_in_range: got %b expected 0", inr_m); end
    n_checks++; if (ovf_m !== 1'b0) begin n_fail++; $display("FAIL low_overflow: got %b expected 0", ovf_m); end
    // Stuck high straight out of reset: first start right after warmup.
    mode_m = 1;
    rst_m = 1'b1;
    tick(3);
    rst_m = 1'b0;
    tick(3);
    run_window(130, 0, 0, bc, da, nd);
    n_checks++; if (da != 101) begin n_fail++; $display("FAIL high_done_at: got %0d expected 101", da); end
    n_checks++; if (count_m !== 8'd0) begin n_fail++; $display("FAIL high_count: got %0d expected 0", count_m); end
    n_checks++; if (inr_m !== 1'b0) begin n_fail++; $display("FAIL high_in_range: got %b expected 0", inr_m); end
  endtask

  task automatic test_saturate;
    int da, nd;
    da = -1; nd = 0;
    start_s = 1'b1;
    for (int i = 1; i <= 130; i++) begin
      @(negedge clk);
      start_s = 1'b0;
      if (done_s) begin nd++; if (da < 0) da = i; end
    end
    n_checks++; if (da != 101 || nd != 1) begin n_fail++;
      $display("FAIL sat_done: got at %0d x%0d expected at 101 x1", da, nd); end
    n_checks++; if (count_s !== 4'd15) begin n_fail++; $display("FAIL sat_count: got %0d expected 15", count_s); end
    n_checks++; if (ovf_s !== 1'b1) begin n_fail++; $display("FAIL sat_overflow: got %b expected 1", ovf_s); end
    n_checks++; if (inr_s !== 1'b0) begin n_fail++; $display("FAIL sat_in_range: got %b expected 0", inr_s); end
  endtask

  task automatic test_restart_ignored;
    int bc, da, nd;
    mode_m = 2;
    tick(5);
    run_window(130, 10, 50, bc, da, nd);
    n_checks++; if (nd != 1) begin n_fail++; $display("FAIL restart_done_pulses: got %0d expected 1", nd); end
    n_checks++; if (da != 101) begin n_fail++; $display("FAIL restart_done_at: got %0d expected 101", da); end
    n_checks++; if (bc != 100) begin n_fail++; $display("FAIL restart_busy_cycles: got %0d expected 100", bc); end
    n_checks++; if (count_m !== 8'd20) begin n_fail++; $display("FAIL restart_count: got %0d expected 20", count_m); end
  endtask

  task automatic test_reset_mid;
    int bc, da, nd, seen_busy, seen_done;
    seen_busy = 0; seen_done = 0;
    start_m = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      start_m = 1'b0;
    end
    n_checks++; if (busy_m !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before_rst: got %b expected 1", busy_m); end
    rst_m = 1'b1;
    #1;
    n_checks++; if ({busy_m, done_m, inr_m, ovf_m} !== 4'b0) begin n_fail++;
      $display("FAIL mid_rst_flags: got %b expected 0000", {busy_m, done_m, inr_m, ovf_m}); end
    n_checks++; if (count_m !== 8'd0) begin n_fail++; $display("FAIL mid_rst_count: got %0d expected 0", count_m); end
    tick(5);
    rst_m = 1'b0;
    start_m = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      start_m = (i < 3) ? 1'b1 : 1'b0;
      if (busy_m) seen_busy++;
      if (done_m) seen_done++;
    end
    n_checks++; if (seen_busy != 0 || seen_done != 0) begin n_fail++;
      $display("FAIL warmup_start_ignored: got busy %0d done %0d expected 0 0", seen_busy, seen_done); end
    run_window(130, 0, 0, bc, da, nd);
    n_checks++; if (da != 101) begin n_fail++; $display("FAIL post_rst_done_at: got %0d expected 101", da); end
    n_checks++; if (count_m !== 8'd20) begin n_fail++; $display("FAIL post_rst_count: got %0d expected 20", count_m); end
  endtask

  task automatic test_continuous;
    int gap, busy_low;
    busy_low = 0; gap = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      gap = i;
      if (done_c) break;
    end
    n_checks++; if (done_c !== 1'b1) begin n_fail++; $display("FAIL cont_first_done: got %b expected 1 within 300", done_c); end
    for (int w = 0; w < 3; w++) begin
      gap = 0;
      for (int i = 1; i <= 150; i++) begin
        @(negedge clk);
        if (!busy_c) busy_low++;
        if (done_c) begin gap = i; break; end
      end
      n_checks++; if (gap != 100) begin n_fail++; $display("FAIL cont_period_w%0d: got %0d expected 100", w, gap); end
      n_checks++; if (count_c !== 8'd20) begin n_fail++; $display("FAIL cont_count_w%0d: got %0d expected 20", w, count_c); end
      n_checks++; if (inr_c !== 1'b1 || ovf_c !== 1'b0) begin n_fail++;
        $display("FAIL cont_flags_w%0d: got inr %b ovf %b expected 1 0", w, inr_c, ovf_c); end
    end
    n_checks++; if (busy_low != 0) begin n_fail++; $display("FAIL cont_busy_drop: got %0d low cycles expected 0", busy_low); end
  endtask

  initial begin
    test_reset();
    test_square5();
    test_stuck();
    test_saturate();
    test_restart_ignored();
    test_reset_mid();
    test_continuous();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
